// File: rtl/fp_add_arbiter.sv
// Round-robin front end that shares one multi-cycle FP adder among N_REQ clients.
// Adds a zero-operand bypass, a watchdog on fpu_done and one-hot response strobes.
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic                 clock_100kHz,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_op_a,
    input  logic [32*N_REQ-1:0]  req_op_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [3:0]           rsp_status,
    output logic                 fpu_start,
    output logic [31:0]          fpu_op_a,
    output logic [31:0]          fpu_op_b,
    input  logic                 fpu_done,
    input  logic [31:0]          fpu_result,
    input  logic [3:0]           fpu_status,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [1:0]           dbg_state
);

    // Handshake: requester i is accepted on a rising edge where req_valid[i] & req_ready[i];
    // req_ready is only ever raised in IDLE, one-hot, and valid may drop at any time before that.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [3:0] ST_EXACT   = 4'd0;
    localparam logic [3:0] ST_TIMEOUT = 4'd8;

    state_t          state;
    state_t          state_d;
    logic [IDW-1:0]  last_grant;
    logic [CW-1:0]   wd_cnt;
    logic [31:0]     op_a_arr [N_REQ];
    logic [31:0]     op_b_arr [N_REQ];
    logic            found;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  idx;
    logic [31:0]     win_a;
    logic [31:0]     win_b;
    logic            accept;
    logic            byp_b;
    logic            byp_a;
    logic            wd_expired;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_a_arr[g] = req_op_a[32*g +: 32];
        assign op_b_arr[g] = req_op_b[32*g +: 32];
    end

    // Rotating priority: first pending requester after the previous owner, wrapping around.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    assign win_a      = op_a_arr[win_id];
    assign win_b      = op_b_arr[win_id];
    assign accept     = (state == IDLE) && found;
    assign byp_b      = (win_b[30:0] == 31'd0);
    assign byp_a      = (win_a[30:0] == 31'd0);
    assign wd_expired = (wd_cnt == WD_LAST);

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        req_ready = '0;
        rsp_valid = '0;
        fpu_start = 1'b0;
        busy      = (state != IDLE);
        dbg_state = state;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[win_id] = 1'b1;
                end
                if (accept) begin
                    state_d = (byp_b || byp_a) ? RESPOND : ISSUE;
                end
            end
            ISSUE: begin
                fpu_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (fpu_done || wd_expired) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid[grant_id] = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response word is written on entry to RESPOND and held until the next one.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            last_grant <= IDW'(N_REQ - 1);
            grant_id   <= '0;
            wd_cnt     <= '0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_op_a <= win_a;
                        fpu_op_b <= win_b;
                        grant_id <= win_id;
                        if (byp_b) begin
                            rsp_data   <= win_a;
                            rsp_status <= ST_EXACT;
                        end else if (byp_a) begin
                            rsp_data   <= win_b;
                            rsp_status <= ST_EXACT;
                        end
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (fpu_done) begin
                        rsp_data   <= fpu_result;
                        rsp_status <= fpu_status;
                    end else if (wd_expired) begin
                        rsp_data   <= '0;
                        rsp_status <= ST_TIMEOUT;
                    end
                end
                RESPOND: begin
                    last_grant <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: randomized requests against a transaction-level
// model of arbitration order, bypass, adder and watchdog behaviour.
module tb_fp_add_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic              clock_100kHz = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_op_a;
    logic [32*N-1:0]   req_op_b;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_data;
    logic [3:0]        rsp_status;
    logic              fpu_start;
    logic [31:0]       fpu_op_a;
    logic [31:0]       fpu_op_b;
    logic              fpu_done;
    logic [31:0]       fpu_result;
    logic [3:0]        fpu_status;
    logic              busy;
    logic [1:0]        grant_id;
    logic [1:0]        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int ref_last = N - 1;
    logic [31:0] exp_q[$];

    logic [N-1:0] o_ready, o_rsp;
    logic [31:0]  o_data, o_fa, o_fb;
    logic [3:0]   o_stat;
    int o_gid, o_starts, o_lat, o_rcyc, o_rbusy;
    logic [31:0]  e_data;
    logic [3:0]   e_stat;
    int e_lat, e_starts;

    fp_add_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clock_100kHz(clock_100kHz), .reset(reset),
        .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .fpu_start(fpu_start), .fpu_op_a(fpu_op_a),
        .fpu_op_b(fpu_op_b), .fpu_done(fpu_done), .fpu_result(fpu_result),
        .fpu_status(fpu_status), .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
    );

    // Clock and global time limit
    always #5 clock_100kHz = ~clock_100kHz;

    initial begin
        #2000000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    // Reference model: rotating priority order and the response rules
    function automatic int ref_pick(input logic [N-1:0] mask, input int last);
        int m;
        m = int'(mask);
        for (int k = 1; k <= N; k++) begin
            if (((m >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic void ref_expect(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] res, input logic [3:0] st, input int lat);
        if (b[30:0] == 31'd0) begin
            e_data = a; e_stat = 4'd0; e_lat = 1; e_starts = 0;
        end else if (a[30:0] == 31'd0) begin
            e_data = b; e_stat = 4'd0; e_lat = 1; e_starts = 0;
        end else if (lat >= 1 && lat <= TO) begin
            e_data = res; e_stat = st; e_lat = 2 + lat; e_starts = 1;
        end else begin
            e_data = 32'd0; e_stat = 4'd8; e_lat = 2 + TO; e_starts = 1;
        end
    endfunction

    function automatic logic [31:0] rnd_op(input int zero_pct);
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(99, 0) < zero_pct) r[30:0] = 31'd0;
        else if (r[30:0] == 31'd0) r[0] = 1'b1;
        return r;
    endfunction

    // Driver: present a request, then play the adder (done 'lat' cycles after start, never if lat<1)
    task automatic run_op(input logic [N-1:0] mask, input logic [32*N-1:0] opa,
                          input logic [32*N-1:0] opb, input int lat,
                          input logic [31:0] res, input logic [3:0] st);
        int cd;
        bit got;
        req_valid = mask; req_op_a = opa; req_op_b = opb;
        #1 o_ready = req_ready;
        @(posedge clock_100kHz); #1;
        o_gid = int'(grant_id);
        o_starts = 0; o_lat = -1; o_rcyc = 0; o_rbusy = 0;
        o_rsp = '0; o_data = '0; o_stat = '0; o_fa = '0; o_fb = '0;
        cd = -1; got = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            fpu_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fpu_done = 1'b1; fpu_result = res; fpu_status = st; cd = -1;
                end
            end
            if (fpu_start) begin
                o_starts++; o_fa = fpu_op_a; o_fb = fpu_op_b;
                if (lat > 0) cd = lat;
            end
            if (busy && req_ready != '0) o_rbusy++;
            if (rsp_valid != '0) begin
                o_rcyc++;
                if (!got) begin
                    got = 1'b1; o_lat = cyc; o_rsp = rsp_valid; o_data = rsp_data; o_stat = rsp_status;
                end
            end else if (got) begin
                break;
            end
            @(posedge clock_100kHz); #1;
        end
        fpu_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = '0; req_op_a = '0; req_op_b = '0;
        fpu_done = 1'b0; fpu_result = '0; fpu_status = '0;
        repeat (3) @(posedge clock_100kHz);
        #1;
        n_vec++; if (req_ready !== '0)  begin n_err++; $display("FAIL rst_req_ready got=%0h exp=0", req_ready); end
        n_vec++; if (rsp_valid !== '0)  begin n_err++; $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); end
        n_vec++; if (rsp_data !== '0)   begin n_err++; $display("FAIL rst_rsp_data got=%0h exp=0", rsp_data); end
        n_vec++; if (rsp_status !== '0) begin n_err++; $display("FAIL rst_rsp_status got=%0h exp=0", rsp_status); end
        n_vec++; if (fpu_start !== 1'b0) begin n_err++; $display("FAIL rst_fpu_start got=%0b exp=0", fpu_start); end
        n_vec++; if (fpu_op_a !== '0 || fpu_op_b !== '0) begin n_err++; $display("FAIL rst_fpu_ops got=%0h/%0h exp=0/0", fpu_op_a, fpu_op_b); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        n_vec++; if (grant_id !== '0)   begin n_err++; $display("FAIL rst_grant_id got=%0h exp=0", grant_id); end
        n_vec++; if (dbg_state !== '0)  begin n_err++; $display("FAIL rst_state got=%0h exp=0", dbg_state); end
        reset = 1'b1;
        @(posedge clock_100kHz); #1;
        ref_last = N - 1;
    endtask

    task automatic test_basic();
        run_op(4'b0001, {96'd0, 32'h3E000000}, {96'd0, 32'h3E000000}, 2, 32'h40000000, 4'd0);
        req_valid = '0;
        n_vec++; if (o_ready !== 4'b0001) begin n_err++; $display("FAIL basic_ready got=%0h exp=1", o_ready); end
        n_vec++; if (o_starts != 1)       begin n_err++; $display("FAIL basic_starts got=%0d exp=1", o_starts); end
        n_vec++; if (o_fa !== 32'h3E000000 || o_fb !== 32'h3E000000) begin n_err++; $display("FAIL basic_fpu_ops got=%0h/%0h exp=3e000000", o_fa, o_fb); end
        n_vec++; if (o_rsp !== 4'b0001)   begin n_err++; $display("FAIL basic_rsp_valid got=%0h exp=1", o_rsp); end
        n_vec++; if (o_data !== 32'h40000000) begin n_err++; $display("FAIL basic_rsp_data got=%0h exp=40000000", o_data); end
        n_vec++; if (o_stat !== 4'd0)     begin n_err++; $display("FAIL basic_rsp_status got=%0h exp=0", o_stat); end
        n_vec++; if (o_lat != 4)          begin n_err++; $display("FAIL basic_latency got=%0d exp=4", o_lat); end
        n_vec++; if (o_rcyc != 1)         begin n_err++; $display("FAIL basic_rsp_cycles got=%0d exp=1", o_rcyc); end
        ref_last = 0;
    endtask

    task automatic test_round_robin();
        logic [32*N-1:0] a, b;
        logic [31:0] res;
        int w, lat;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < N; j++) begin a[32*j +: 32] = rnd_op(0); b[32*j +: 32] = rnd_op(0); end
            res = $urandom; lat = $urandom_range(6, 1);
            w = ref_pick(4'b1111, ref_last);
            ref_expect(a[32*w +: 32], b[32*w +: 32], res, 4'd3, lat);
            run_op(4'b1111, a, b, lat, res, 4'd3);
            n_vec++; if (o_ready !== 4'(1 << w)) begin n_err++; $display("FAIL rr_ready[%0d] got=%0h exp=%0h", i, o_ready, 4'(1 << w)); end
            n_vec++; if (o_gid != w)             begin n_err++; $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", i, o_gid, w); end
            n_vec++; if (o_rsp !== 4'(1 << w))   begin n_err++; $display("FAIL rr_rsp_valid[%0d] got=%0h exp=%0h", i, o_rsp, 4'(1 << w)); end
            n_vec++; if (o_data !== e_data)      begin n_err++; $display("FAIL rr_rsp_data[%0d] got=%0h exp=%0h", i, o_data, e_data); end
            n_vec++; if (o_lat != e_lat)         begin n_err++; $display("FAIL rr_latency[%0d] got=%0d exp=%0d", i, o_lat, e_lat); end
            n_vec++; if (o_fa !== a[32*w +: 32]) begin n_err++; $display("FAIL rr_fpu_op_a[%0d] got=%0h exp=%0h", i, o_fa, a[32*w +: 32]); end
            n_vec++; if (o_rbusy != 0)           begin n_err++; $display("FAIL rr_ready_while_busy[%0d] got=%0d exp=0", i, o_rbusy); end
            ref_last = w;
        end
        req_valid = '0;
    endtask

    task automatic test_bypass();
        run_op(4'b0100, {32'd0, 32'h3E000000, 64'd0}, 128'd0, 2, 32'hDEADBEEF, 4'd1);
        n_vec++; if (o_starts != 0)       begin n_err++; $display("FAIL byp_starts got=%0d exp=0", o_starts); end
        n_vec++; if (o_rsp !== 4'b0100)   begin n_err++; $display("FAIL byp_rsp_valid got=%0h exp=4", o_rsp); end
        n_vec++; if (o_lat != 1)          begin n_err++; $display("FAIL byp_latency got=%0d exp=1", o_lat); end
        n_vec++; if (o_data !== 32'h3E000000 || o_stat !== 4'd0) begin n_err++; $display("FAIL byp_rsp got=%0h/%0h exp=3e000000/0", o_data, o_stat); end
        run_op(4'b0100, {32'd0, 32'h80000000, 64'd0}, 128'd0, 2, 32'hDEADBEEF, 4'd1);
        n_vec++; if (o_data !== 32'h80000000 || o_starts != 0) begin n_err++; $display("FAIL byp_both_zero got=%0h/%0d exp=80000000/0", o_data, o_starts); end
        run_op(4'b0100, 128'd0, {32'd0, 32'h3F800000, 64'd0}, 2, 32'hDEADBEEF, 4'd1);
        n_vec++; if (o_data !== 32'h3F800000 || o_lat != 1) begin n_err++; $display("FAIL byp_a_zero got=%0h/%0d exp=3f800000/1", o_data, o_lat); end
        req_valid = '0;
        ref_last = 2;
    endtask

    task automatic test_timeout();
        run_op(4'b0001, {96'd0, 32'h3E000000}, {96'd0, 32'h3E000000}, -1, 32'h0, 4'd0);
        n_vec++; if (o_lat != 2 + TO)     begin n_err++; $display("FAIL to_latency got=%0d exp=%0d", o_lat, 2 + TO); end
        n_vec++; if (o_data !== 32'd0 || o_stat !== 4'd8) begin n_err++; $display("FAIL to_rsp got=%0h/%0h exp=0/8", o_data, o_stat); end
        n_vec++; if (o_rsp !== 4'b0001 || o_rcyc != 1) begin n_err++; $display("FAIL to_rsp_valid got=%0h/%0d exp=1/1", o_rsp, o_rcyc); end
        run_op(4'b0001, {96'd0, 32'h3E000000}, {96'd0, 32'h3E000000}, TO, 32'h12345678, 4'd3);
        n_vec++; if (o_data !== 32'h12345678 || o_stat !== 4'd3 || o_lat != 2 + TO) begin n_err++; $display("FAIL to_done_at_expiry got=%0h/%0h/%0d exp=12345678/3/%0d", o_data, o_stat, o_lat, 2 + TO); end
        run_op(4'b0010, {64'd0, 32'h3E000000, 32'd0}, {64'd0, 32'h3E800000, 32'd0}, 3, 32'h3F000000, 4'd0);
        n_vec++; if (o_rsp !== 4'b0010 || o_data !== 32'h3F000000 || o_lat != 5) begin n_err++; $display("FAIL to_next_normal got=%0h/%0h/%0d exp=2/3f000000/5", o_rsp, o_data, o_lat); end
        req_valid = '0;
        ref_last = 1;
    endtask

    task automatic test_status_spurious();
        int rsp_cnt;
        run_op(4'b1000, {32'h7E000000, 96'd0}, {32'h7E000000, 96'd0}, 2, 32'h7FFFFFFF, 4'd1);
        req_valid = '0;
        n_vec++; if (o_stat !== 4'd1 || o_data !== 32'h7FFFFFFF) begin n_err++; $display("FAIL ovf_rsp got=%0h/%0h exp=7fffffff/1", o_data, o_stat); end
        fpu_done = 1'b1; fpu_result = 32'hCAFEF00D; fpu_status = 4'd2;
        @(posedge clock_100kHz); #1;
        fpu_done = 1'b0;
        rsp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid != '0 || busy) rsp_cnt++;
            @(posedge clock_100kHz); #1;
        end
        n_vec++; if (rsp_cnt != 0)          begin n_err++; $display("FAIL spurious_activity got=%0d exp=0", rsp_cnt); end
        n_vec++; if (dbg_state !== 2'd0)    begin n_err++; $display("FAIL spurious_state got=%0h exp=0", dbg_state); end
        n_vec++; if (rsp_data !== 32'h7FFFFFFF || rsp_status !== 4'd1) begin n_err++; $display("FAIL spurious_hold got=%0h/%0h exp=7fffffff/1", rsp_data, rsp_status); end
        ref_last = 3;
    endtask

    task automatic test_random();
        logic [32*N-1:0] a, b;
        logic [31:0] res, exp_d;
        logic [3:0] st;
        logic [N-1:0] mask;
        int w, lat;
        for (int i = 0; i < 24; i++) begin
            mask = 4'($urandom_range(15, 1));
            for (int j = 0; j < N; j++) begin a[32*j +: 32] = rnd_op(25); b[32*j +: 32] = rnd_op(25); end
            res = $urandom; st = 4'($urandom_range(3, 0)); lat = $urandom_range(5, 1);
            w = ref_pick(mask, ref_last);
            ref_expect(a[32*w +: 32], b[32*w +: 32], res, st, lat);
            exp_q.push_back(e_data);
            run_op(mask, a, b, lat, res, st);
            exp_d = exp_q.pop_front();
            n_vec++; if (o_ready !== 4'(1 << w)) begin n_err++; $display("FAIL rnd_ready[%0d] got=%0h exp=%0h", i, o_ready, 4'(1 << w)); end
            n_vec++; if (o_rsp !== 4'(1 << w))   begin n_err++; $display("FAIL rnd_rsp_valid[%0d] got=%0h exp=%0h", i, o_rsp, 4'(1 << w)); end
            n_vec++; if (o_data !== exp_d)       begin n_err++; $display("FAIL rnd_rsp_data[%0d] got=%0h exp=%0h", i, o_data, exp_d); end
            n_vec++; if (o_stat !== e_stat)      begin n_err++; $display("FAIL rnd_rsp_status[%0d] got=%0h exp=%0h", i, o_stat, e_stat); end
            n_vec++; if (o_lat != e_lat || o_starts != e_starts) begin n_err++; $display("FAIL rnd_timing[%0d] got=%0d/%0d exp=%0d/%0d", i, o_lat, o_starts, e_lat, e_starts); end
            ref_last = w;
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_wait();
        int rsp_cnt;
        req_valid = 4'b0100; req_op_a = {32'd0, 32'h3E000000, 64'd0}; req_op_b = {32'd0, 32'h3E000000, 64'd0};
        @(posedge clock_100kHz); #1;
        req_valid = '0;
        repeat (4) @(posedge clock_100kHz);
        #1;
        n_vec++; if (busy !== 1'b1 || fpu_start !== 1'b0) begin n_err++; $display("FAIL mid_in_wait got=%0b/%0b exp=1/0", busy, fpu_start); end
        reset = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || grant_id !== '0 || dbg_state !== '0) begin n_err++; $display("FAIL mid_rst_ctrl got=%0b/%0h/%0h exp=0/0/0", busy, grant_id, dbg_state); end
        n_vec++; if (fpu_op_a !== '0 || fpu_op_b !== '0 || rsp_data !== '0 || rsp_status !== '0) begin n_err++; $display("FAIL mid_rst_data got=%0h/%0h/%0h/%0h exp=0", fpu_op_a, fpu_op_b, rsp_data, rsp_status); end
        rsp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid != '0 || fpu_start) rsp_cnt++;
            if (i == 2) reset = 1'b1;
            @(posedge clock_100kHz); #1;
        end
        n_vec++; if (rsp_cnt != 0) begin n_err++; $display("FAIL mid_abandoned_rsp got=%0d exp=0", rsp_cnt); end
        ref_last = N - 1;
        run_op(4'b1111, {4{32'h3E000000}}, {4{32'h3E000000}}, 1, 32'h40000000, 4'd0);
        req_valid = '0;
        n_vec++; if (o_ready !== 4'b0001 || o_rsp !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant got=%0h/%0h exp=1/1", o_ready, o_rsp); end
        n_vec++; if (o_lat != 3) begin n_err++; $display("FAIL mid_min_latency got=%0d exp=3", o_lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_bypass();
        test_timeout();
        test_status_spurious();
        test_random();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
